// File: rtl/register_norm.sv
// Shift register with parallel load, serial shifts and multi-cycle auto-normalize.
// Optional sticky tracking of bits lost by right shifts: define REGISTER_NORM_STICKY_EN.
module register_norm #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             sld,
  input  logic             srd,
  input  logic             sin,
  input  logic             norm,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             sticky
);

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             busy_q, done_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      StNorm: begin
        out_d = {out_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        // Bit WIDTH-2 becomes the MSB after this shift, so normalization ends here.
        if (out_q[WIDTH-2]) state_d = StDone;
      end
      default: begin
        state_d = StIdle;
        if (ld) begin
          out_d = in;
        end else if (norm) begin
          cnt_d  = '0;
          zero_d = 1'b0;
          if (out_q == '0) begin
            zero_d  = 1'b1;
            state_d = StDone;
          end else if (out_q[WIDTH-1]) begin
            state_d = StDone;
          end else begin
            state_d = StNorm;
          end
        end else if (sld) begin
          out_d = {out_q[WIDTH-2:0], sin};
        end else if (srd) begin
          out_d = {sin, out_q[WIDTH-1:1]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= (state_d == StNorm);
      done_q  <= (state_d == StDone);
    end
  end

`ifdef REGISTER_NORM_STICKY_EN
  logic sticky_q;
  logic ld_acc, srd_acc;

  assign ld_acc  = (state_q != StNorm) && ld;
  assign srd_acc = (state_q != StNorm) && !ld && !norm && !sld && srd;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (ld_acc) begin
      sticky_q <= 1'b0;
    end else if (srd_acc) begin
      sticky_q <= sticky_q | out_q[0];
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign out  = out_q;
  assign cnt  = cnt_q;
  assign zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_register_norm.sv
// Directed bench for register_norm: a result-level model checked every cycle plus literal pins.
module tb_register_norm;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst, ld, sld, srd, sin, norm;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out;
  logic             busy, done, zero, sticky;
  logic [CNT_W-1:0] cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  register_norm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .in(din), .sld(sld), .srd(srd), .sin(sin),
    .norm(norm), .out(out), .busy(busy), .done(done), .cnt(cnt), .zero(zero),
    .sticky(sticky)
  );

  always #5 clk = ~clk;

  // Model: normalization is computed in one go; busy just counts down the shift count.
  logic [WIDTH-1:0] m_out, m_target;
  int               m_cnt, m_target_cnt, m_left;
  logic             m_busy, m_done, m_zero, m_sticky;

  initial begin
    m_out = '0; m_cnt = 0; m_busy = 0; m_done = 0; m_zero = 0; m_sticky = 0;
    m_left = 0; m_target = '0; m_target_cnt = 0;
  end

  always @(posedge clk) begin
    int lz;
    if (rst) begin
      m_out = '0; m_cnt = 0; m_busy = 0; m_done = 0; m_zero = 0; m_sticky = 0; m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_out  = m_target;
        m_cnt  = m_target_cnt;
      end
    end else begin
      m_done = 0;
      if (ld) begin
        m_out    = din;
        m_sticky = 0;
      end else if (norm) begin
        m_cnt  = 0;
        m_zero = (m_out == 0);
        if (m_out == 0 || m_out[WIDTH-1]) begin
          m_done = 1;
        end else begin
          lz = 0;
          for (int b = WIDTH - 1; b >= 0; b--) begin
            if (m_out[b]) begin
              lz = WIDTH - 1 - b;
              break;
            end
          end
          m_busy       = 1;
          m_left       = lz;
          m_target     = m_out << lz;
          m_target_cnt = lz;
        end
      end else if (sld) begin
        m_out = (m_out << 1) | WIDTH'(sin);
      end else if (srd) begin
        m_sticky = m_sticky | m_out[0];
        m_out    = (m_out >> 1) | (WIDTH'(sin) << (WIDTH - 1));
      end
`ifndef REGISTER_NORM_STICKY_EN
      m_sticky = 0;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", 32'(busy), 32'(m_busy));
      check("model done", 32'(done), 32'(m_done));
      check("model zero", 32'(zero), 32'(m_zero));
      check("model sticky", 32'(sticky), 32'(m_sticky));
      if (!m_busy) begin
        check("model out", 32'(out), 32'(m_out));
        check("model cnt", 32'(cnt), 32'(m_cnt));
      end
    end
  end

  task automatic step(input logic l, input logic [WIDTH-1:0] d, input logic sl,
                      input logic sr, input logic s, input logic n);
    ld = l; din = d; sld = sl; srd = sr; sin = s; norm = n;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out"}, 32'(out), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " done"}, 32'(done), 32'h0);
    check({tag, " cnt"}, 32'(cnt), 32'h0);
    check({tag, " zero"}, 32'(zero), 32'h0);
    check({tag, " sticky"}, 32'(sticky), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    ld = 0; din = '0; sld = 0; srd = 0; sin = 0; norm = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_all_zero("reset");

    // Load and shifts
    step(1'b1, 24'h00103C, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sld x5 out", 32'(out), 32'h020780);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("srd sin1 out", 32'(out), 32'h8103C0);

    // Full-length normalize
    step(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 23; i++) begin
      check("norm23 busy", 32'(busy), 32'h1);
      idle();
    end
    check("norm23 busy end", 32'(busy), 32'h0);
    check("norm23 done", 32'(done), 32'h1);
    check("norm23 out", 32'(out), 32'h800000);
    check("norm23 cnt", 32'(cnt), 32'd23);
    check("norm23 zero", 32'(zero), 32'h0);
    idle();
    check("norm23 done pulse", 32'(done), 32'h0);

    // Zero and already-normalized cases
    step(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("zero done", 32'(done), 32'h1);
    check("zero flag", 32'(zero), 32'h1);
    check("zero cnt", 32'(cnt), 32'h0);
    step(1'b1, 24'h900000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("msb done", 32'(done), 32'h1);
    check("msb cnt", 32'(cnt), 32'h0);
    check("msb out", 32'(out), 32'h900000);
    check("msb zero", 32'(zero), 32'h0);

    // Commands ignored while normalizing
    step(1'b1, 24'h000100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    check("ignore done", 32'(done), 32'h1);
    check("ignore out", 32'(out), 32'h800000);
    check("ignore cnt", 32'(cnt), 32'd15);

    // Reset in the middle of NORM
    step(1'b1, 24'h000100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_all_zero("midrst");
    idle();
    check("midrst idle busy", 32'(busy), 32'h0);

    // norm accepted from DONE; ld wins over norm
    step(1'b1, 24'h400000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("k22 done", 32'(done), 32'h1);
    check("k22 cnt", 32'(cnt), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("renorm done", 32'(done), 32'h1);
    check("renorm cnt", 32'(cnt), 32'h0);
    step(1'b1, 24'h000010, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ld prio busy", 32'(busy), 32'h0);
    check("ld prio out", 32'(out), 32'h000010);

    // Sticky from right shifts
    step(1'b1, 24'h000003, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("srd2 out", 32'(out), 32'h0);
`ifdef REGISTER_NORM_STICKY_EN
    check("srd2 sticky", 32'(sticky), 32'h1);
`else
    check("srd2 sticky", 32'(sticky), 32'h0);
`endif
    step(1'b1, 24'h000005, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ld clears sticky", 32'(sticky), 32'h0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
